chroni_vram_arbiter: RTL

- Single-port VRAM arbiter directly upstream of the chroni video fetch port.
- Multiplexes chroni display fetches (absolute priority, fixed latency) with CPU read/write accesses on a 21-bit byte address space (8-bit page + 13-bit offset).
- CPU writes are posted through a one-entry write buffer so the CPU rarely stalls during active display.
- Exposes a sticky starvation flag for debug.

---
 rtl/chroni_vram_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/chroni_vram_arbiter.sv
// Single-port VRAM arbiter: chroni video fetches take absolute priority, CPU
// reads wait for a free slot, CPU writes are posted through a one-entry buffer.
module chroni_vram_arbiter #(
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        vid_req,
  input  logic [12:0] vid_addr,
  input  logic [7:0]  vid_page,
  output logic [7:0]  vid_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [20:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_starved,
  output logic [20:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata
);

  localparam int unsigned ADDR_W = 21;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DATA  = 2'd2,
    ACK      = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic               wb_valid;
  logic [ADDR_W-1:0]  wb_addr;
  logic [DATA_W-1:0]  wb_data;
  logic               wb_hit;
  logic               drain;
  logic               slot_cpu;

  logic               wb_load;
  logic               fwd_rd;
  logic               ram_rd_done;
  logic               ack_set;

  logic               vid_pending;
  logic [CNT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]   wait_cnt_nxt;

  assign wb_hit   = (wb_addr == cpu_addr);
  assign drain    = ~vid_req & wb_valid;
  assign slot_cpu = ~vid_req & ~wb_valid;
  assign ack_set  = wb_load | fwd_rd | ram_rd_done;

  // Slot owner this cycle: video, then buffered write, then a pending CPU read.
  always_comb begin : slot_mux
    ram_addr  = {vid_page, vid_addr};
    ram_we    = 1'b0;
    ram_wdata = wb_data;
    if (!vid_req) begin
      if (wb_valid) begin
        ram_addr = wb_addr;
        ram_we   = reset_n;
      end else if (state == RD_ISSUE) begin
        ram_addr = cpu_addr;
      end
    end
  end

  always_ff @(posedge vga_clk) begin : state_reg
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin : next_state
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            if (!wb_valid) state_nxt = ACK;
          end else if (!wb_valid) begin
            state_nxt = RD_ISSUE;
          end else if (wb_hit) begin
            state_nxt = ACK;
          end
        end
      end
      RD_ISSUE: if (slot_cpu) state_nxt = RD_DATA;
      RD_DATA:  state_nxt = ACK;
      ACK:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Completion strobes; a mismatching read or a write behind a full buffer waits in IDLE.
  always_comb begin : fsm_outputs
    wb_load     = 1'b0;
    fwd_rd      = 1'b0;
    ram_rd_done = 1'b0;
    case (state)
      IDLE: begin
        wb_load = cpu_req & cpu_we & ~wb_valid;
        fwd_rd  = cpu_req & ~cpu_we & wb_valid & wb_hit;
      end
      RD_DATA: ram_rd_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge vga_clk) begin : write_buffer
    if (!reset_n) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else if (wb_load) begin
      wb_valid <= 1'b1;
      wb_addr  <= cpu_addr;
      wb_data  <= cpu_wdata;
    end else if (drain) begin
      wb_valid <= 1'b0;
    end
  end

  always_ff @(posedge vga_clk) begin : read_path
    if (!reset_n) begin
      vid_pending <= 1'b0;
      vid_data    <= '0;
      cpu_rdata   <= '0;
      cpu_ack     <= 1'b0;
    end else begin
      vid_pending <= vid_req;
      if (vid_pending) vid_data <= ram_rdata;
      cpu_ack <= ack_set;
      if (fwd_rd) begin
        cpu_rdata <= wb_data;
      end else if (ram_rd_done) begin
        cpu_rdata <= ram_rdata;
      end
    end
  end

  always_comb begin : wait_count
    wait_cnt_nxt = wait_cnt;
    if (ack_set) begin
      wait_cnt_nxt = '0;
    end else if (cpu_req && (state != ACK) && (wait_cnt != CNT_MAX)) begin
      wait_cnt_nxt = wait_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge vga_clk) begin : starvation
    if (!reset_n) begin
      wait_cnt    <= '0;
      cpu_starved <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
      if (wait_cnt_nxt >= WAIT_LIMIT) cpu_starved <= 1'b1;
    end
  end

endmodule
